// File: rtl/ieu_bypass_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ieu_bypass_pipe_pkg
// Description : Shared types and helpers for the integer result pipeline.
//               A stage entry is {valid, rd, ready, data}. The data field
//               width depends on XLEN, so it is kept as a separate array
//               next to this packed tag.
// Revision    : 1.0 - initial release
// ============================================================================
package ieu_bypass_pipe_pkg;

  localparam int RIDX_W = 5;

  // Control part of a stage entry.
  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              ready;
  } stage_tag_t;

  // A register index takes part in forwarding and write-back only when it is
  // non-zero and implemented (RV32E/RV64E have 16 registers).
  function automatic logic reg_ok(input logic [RIDX_W-1:0] r, input int nregs);
    return (r != '0) && (int'(r) < nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ieu_bypass_pipe_bypass_sel.sv
`default_nettype none
// ============================================================================
// Module      : bypass_sel
// Description : Operand select for one read port. Finds the youngest valid
//               in-flight entry writing i_rs and returns its data, or raises
//               o_hazard when that entry is not ready yet. Falls back to the
//               register file value when nothing in flight matches.
// Ports       : i_tag/i_data  stage entries, index 0 = youngest
//               i_rs          source register index
//               i_rf_data     register file read value for i_rs
//               o_data        forwarded operand
//               o_hazard      youngest matching entry is not ready
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_sel
  import ieu_bypass_pipe_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NSTAGES = 3,
  parameter int NREGS   = 32
) (
  input  stage_tag_t [NSTAGES-1:0]           i_tag,
  input  logic       [NSTAGES-1:0][XLEN-1:0] i_data,
  input  logic       [RIDX_W-1:0]            i_rs,
  input  logic       [XLEN-1:0]              i_rf_data,
  output logic       [XLEN-1:0]              o_data,
  output logic                               o_hazard
);

  logic            w_hit;
  logic            w_hit_ready;
  logic [XLEN-1:0] w_hit_data;

  always_comb begin
    w_hit       = 1'b0;
    w_hit_ready = 1'b0;
    w_hit_data  = '0;
    // Walk oldest to youngest so a younger match overwrites an older one;
    // a not-ready young entry is therefore never hidden by a ready old one.
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (i_tag[k].valid && (i_tag[k].rd == i_rs)) begin
        w_hit       = 1'b1;
        w_hit_ready = i_tag[k].ready;
        w_hit_data  = i_data[k];
      end
    end

    o_data   = i_rf_data;
    o_hazard = 1'b0;
    if (!reg_ok(i_rs, NREGS)) begin
      o_data = '0;
    end else if (w_hit) begin
      if (w_hit_ready) begin
        o_data = w_hit_data;
      end else begin
        o_data   = '0;
        o_hazard = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ieu_bypass_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ieu_bypass_pipe
// Description : Parametrised integer result pipeline S0..S(NSTAGES-1) with
//               per-port operand forwarding, hazard detection, late-result
//               merge at S[LATE_STAGE] and an integrated register file written
//               from the last stage.
// Ports       : clk, reset      clock, asynchronous active-high reset
//               StallS/FlushS   per-stage stall / flush, bit k = Sk
//               ValidE, RdE, ResultE, ReadyE   Execute result into S0
//               LateResult      load data merged on entry to S[LATE_STAGE]
//               RsD             source indices, port i at [5i+4:5i]
//               ReadDataD       forwarded operands, port i at [XLEN*i +: XLEN]
//               HazardD         per-port "needed result not ready"
//               RdW, RegWriteW  register file write this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ieu_bypass_pipe
  import ieu_bypass_pipe_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NSTAGES    = 3,
  parameter int NREAD      = 2,
  parameter int NREGS      = 32,
  parameter int LATE_STAGE = 2   // legal range 1..NSTAGES-1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSTAGES-1:0]      StallS,
  input  logic [NSTAGES-1:0]      FlushS,
  input  logic                    ValidE,
  input  logic [RIDX_W-1:0]       RdE,
  input  logic [XLEN-1:0]         ResultE,
  input  logic                    ReadyE,
  input  logic [XLEN-1:0]         LateResult,
  input  logic [NREAD*RIDX_W-1:0] RsD,
  output logic [NREAD*XLEN-1:0]   ReadDataD,
  output logic [NREAD-1:0]        HazardD,
  output logic [RIDX_W-1:0]       RdW,
  output logic                    RegWriteW
);

  localparam int IDXW = $clog2(NREGS);

  stage_tag_t [NSTAGES-1:0]           w_tag;
  logic       [NSTAGES-1:0][XLEN-1:0] w_data;
  logic       [XLEN-1:0]              r_rf [NREGS];

  // --------------------------------------------------------------------------
  // Result stages
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    stage_tag_t      w_prev_tag;
    logic [XLEN-1:0] w_prev_data;
    logic            w_prev_stall;
    stage_tag_t      r_tag;
    logic [XLEN-1:0] r_data;

    if (k == 0) begin : g_head
      // x0 and unimplemented registers never become valid entries.
      assign w_prev_tag   = '{valid: ValidE & reg_ok(RdE, NREGS), rd: RdE, ready: ReadyE};
      assign w_prev_data  = ResultE;
      assign w_prev_stall = 1'b0;
    end else begin : g_body
      assign w_prev_tag   = w_tag[k-1];
      assign w_prev_data  = w_data[k-1];
      assign w_prev_stall = StallS[k-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_tag  <= '0;
        r_data <= '0;
      end else if (FlushS[k]) begin
        r_tag.valid <= 1'b0;
      end else if (!StallS[k]) begin
        if (w_prev_stall) begin
          // Previous stage holds its entry; do not duplicate it here.
          r_tag.valid <= 1'b0;
        end else if ((k == LATE_STAGE) && !w_prev_tag.ready) begin
          r_tag  <= '{valid: w_prev_tag.valid, rd: w_prev_tag.rd, ready: 1'b1};
          r_data <= LateResult;
        end else begin
          r_tag  <= w_prev_tag;
          r_data <= w_prev_data;
        end
      end
    end

    assign w_tag[k]  = r_tag;
    assign w_data[k] = r_data;
  end

  // --------------------------------------------------------------------------
  // Write-back and register file
  // --------------------------------------------------------------------------
  assign RegWriteW = w_tag[NSTAGES-1].valid & ~StallS[NSTAGES-1];
  assign RdW       = w_tag[NSTAGES-1].rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_rf[r] <= '0;
      end
    end else if (RegWriteW && (w_tag[NSTAGES-1].rd != '0)) begin
      r_rf[w_tag[NSTAGES-1].rd[IDXW-1:0]] <= w_data[NSTAGES-1];
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [RIDX_W-1:0] w_rs;
    logic [XLEN-1:0]   w_rf_val;

    assign w_rs     = RsD[RIDX_W*i +: RIDX_W];
    assign w_rf_val = reg_ok(w_rs, NREGS) ? r_rf[w_rs[IDXW-1:0]] : '0;

    bypass_sel #(
      .XLEN    (XLEN),
      .NSTAGES (NSTAGES),
      .NREGS   (NREGS)
    ) u_sel (
      .i_tag     (w_tag),
      .i_data    (w_data),
      .i_rs      (w_rs),
      .i_rf_data (w_rf_val),
      .o_data    (ReadDataD[XLEN*i +: XLEN]),
      .o_hazard  (HazardD[i])
    );
  end

  // An entry that reached the late-merge stage must carry its final value.
  a_late_ready : assert property (@(posedge clk) disable iff (reset)
    !(w_tag[LATE_STAGE].valid && !w_tag[LATE_STAGE].ready));

endmodule
`default_nettype wire

// File: tb/tb_ieu_bypass_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ieu_bypass_pipe
// Description : Self-checking bench for ieu_bypass_pipe: a table of directed
//               vectors plus short sequences for stall, flush, the 16-register
//               configuration and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ieu_bypass_pipe;

  localparam int XLEN = 64;

  logic             clk;
  logic             reset;
  logic [2:0]       StallS, FlushS;
  logic             ValidE, ReadyE;
  logic [4:0]       RdE;
  logic [XLEN-1:0]  ResultE, LateResult;
  logic [9:0]       RsD;
  logic [2*XLEN-1:0] ReadDataD, ReadDataD_e;
  logic [1:0]       HazardD, HazardD_e;
  logic [4:0]       RdW, RdW_e;
  logic             RegWriteW, RegWriteW_e;

  int n_checks = 0;
  int n_fail   = 0;

  ieu_bypass_pipe dut (
    .clk(clk), .reset(reset), .StallS(StallS), .FlushS(FlushS),
    .ValidE(ValidE), .RdE(RdE), .ResultE(ResultE), .ReadyE(ReadyE),
    .LateResult(LateResult), .RsD(RsD), .ReadDataD(ReadDataD),
    .HazardD(HazardD), .RdW(RdW), .RegWriteW(RegWriteW)
  );

  ieu_bypass_pipe #(.NREGS(16)) dut_e (
    .clk(clk), .reset(reset), .StallS(StallS), .FlushS(FlushS),
    .ValidE(ValidE), .RdE(RdE), .ResultE(ResultE), .ReadyE(ReadyE),
    .LateResult(LateResult), .RsD(RsD), .ReadDataD(ReadDataD_e),
    .HazardD(HazardD_e), .RdW(RdW_e), .RegWriteW(RegWriteW_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ve;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        rdy;
    logic [63:0] late;
    logic [4:0]  rs0, rs1;
    logic [63:0] e0, e1;
    logic        h0, h1, we;
    logic [4:0]  rdw;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ve, input logic [4:0] rd, input logic [63:0] res,
                       input logic rdy, input logic [4:0] rs0, input logic [4:0] rs1);
    ValidE  = ve;
    RdE     = rd;
    ResultE = res;
    ReadyE  = rdy;
    RsD     = {rs1, rs0};
  endtask

  initial begin
    // ve rd res rdy late | rs0 rs1 | e0 e1 h0 h1 we rdw
    vt[0]  = '{1'b1, 5'd5, 64'h1234, 1'b1, 64'h0,    5'd0, 5'd5, 64'h0,    64'h0,    1'b0, 1'b0, 1'b0, 5'd0};
    vt[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    5'd5, 5'd0, 64'h1234, 64'h0,    1'b0, 1'b0, 1'b0, 5'd0};
    vt[2]  = '{1'b1, 5'd7, 64'hDEAD, 1'b0, 64'h0,    5'd5, 5'd7, 64'h1234, 64'h0,    1'b0, 1'b0, 1'b0, 5'd0};
    vt[3]  = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    5'd5, 5'd7, 64'h1234, 64'h0,    1'b0, 1'b1, 1'b1, 5'd5};
    vt[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 64'hCAFE, 5'd5, 5'd7, 64'h1234, 64'h0,    1'b0, 1'b1, 1'b0, 5'd0};
    vt[5]  = '{1'b1, 5'd3, 64'h11,   1'b1, 64'h0,    5'd7, 5'd3, 64'hCAFE, 64'h0,    1'b0, 1'b0, 1'b1, 5'd7};
    vt[6]  = '{1'b1, 5'd3, 64'h22,   1'b1, 64'h0,    5'd3, 5'd7, 64'h11,   64'hCAFE, 1'b0, 1'b0, 1'b0, 5'd0};
    vt[7]  = '{1'b1, 5'd0, 64'hFF,   1'b1, 64'h0,    5'd3, 5'd0, 64'h22,   64'h0,    1'b0, 1'b0, 1'b0, 5'd0};
    vt[8]  = '{1'b1, 5'd3, 64'h99,   1'b0, 64'h0,    5'd3, 5'd0, 64'h22,   64'h0,    1'b0, 1'b0, 1'b1, 5'd3};
    vt[9]  = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    5'd3, 5'd0, 64'h0,    64'h0,    1'b1, 1'b0, 1'b1, 5'd3};
    vt[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h5555, 5'd3, 5'd0, 64'h0,    64'h0,    1'b1, 1'b0, 1'b0, 5'd0};
    vt[11] = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    5'd3, 5'd5, 64'h5555, 64'h1234, 1'b0, 1'b0, 1'b1, 5'd3};
    vt[12] = '{1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    5'd3, 5'd7, 64'h5555, 64'hCAFE, 1'b0, 1'b0, 1'b0, 5'd0};

    reset = 1'b1; StallS = '0; FlushS = '0; LateResult = '0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0);
    tick(); tick();
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].ve, vt[i].rd, vt[i].res, vt[i].rdy, vt[i].rs0, vt[i].rs1);
      LateResult = vt[i].late;
      #1;
      chk($sformatf("v%0d_data0", i), ReadDataD[63:0],   vt[i].e0);
      chk($sformatf("v%0d_data1", i), ReadDataD[127:64], vt[i].e1);
      chk($sformatf("v%0d_haz0", i),  64'(HazardD[0]),   64'(vt[i].h0));
      chk($sformatf("v%0d_haz1", i),  64'(HazardD[1]),   64'(vt[i].h1));
      chk($sformatf("v%0d_we", i),    64'(RegWriteW),    64'(vt[i].we));
      if (vt[i].we) chk($sformatf("v%0d_rdw", i), 64'(RdW), 64'(vt[i].rdw));
      tick();
    end
    LateResult = '0;

    // ---------------- stall on S0 ----------------
    drive(1'b1, 5'd10, 64'hA0, 1'b1, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd11, 64'hB0, 1'b1, 5'd0, 5'd0); tick();
    StallS = 3'b001;
    drive(1'b1, 5'd12, 64'hC0, 1'b1, 5'd11, 5'd10); #1;
    chk("stall_s0_fwd", ReadDataD[63:0], 64'hB0);
    chk("stall_s1_fwd", ReadDataD[127:64], 64'hA0);
    tick(); #1;
    chk("stall_we_tail", 64'(RegWriteW), 64'd1);
    chk("stall_rdw_tail", 64'(RdW), 64'd10);
    tick();
    StallS = 3'b000;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd11, 5'd12); #1;
    chk("stall_we_drop", 64'(RegWriteW), 64'd0);
    chk("stall_held", ReadDataD[63:0], 64'hB0);
    chk("stall_e_lost", ReadDataD[127:64], 64'h0);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd10, 5'd11); #1;
    chk("stall_rf_x10", ReadDataD[63:0], 64'hA0);
    chk("stall_s1_x11", ReadDataD[127:64], 64'hB0);
    tick();

    // ---------------- flush of S1 ----------------
    drive(1'b1, 5'd9, 64'h900, 1'b1, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0); tick(); tick(); tick();
    drive(1'b1, 5'd9, 64'h999, 1'b1, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0); tick();
    FlushS = 3'b010; StallS = 3'b010;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd9, 5'd0); #1;
    chk("flush_pre_fwd", ReadDataD[63:0], 64'h999);
    tick();
    FlushS = 3'b000; StallS = 3'b000; #1;
    chk("flush_no_fwd", ReadDataD[63:0], 64'h900);
    chk("flush_no_we1", 64'(RegWriteW), 64'd0);
    tick(); #1;
    chk("flush_no_we2", 64'(RegWriteW), 64'd0);
    chk("flush_rf_kept", ReadDataD[63:0], 64'h900);
    tick();

    // ---------------- x20 on the 16-register configuration ----------------
    drive(1'b1, 5'd20, 64'h2020, 1'b1, 5'd20, 5'd0); tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd20, 5'd0); #1;
    chk("e16_fwd_zero", ReadDataD_e[63:0], 64'h0);
    chk("e16_haz_zero", 64'(HazardD_e[0]), 64'd0);
    chk("e32_fwd_x20", ReadDataD[63:0], 64'h2020);
    tick(); tick(); #1;
    chk("e32_we_x20", 64'(RegWriteW), 64'd1);
    chk("e16_we_none", 64'(RegWriteW_e), 64'd0);
    chk("e16_tail_zero", ReadDataD_e[63:0], 64'h0);
    tick();

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd4, 5'd5);
    #1;
    chk("pre_reset_fwd", ReadDataD[63:0], 64'h44);
    #1 reset = 1'b1;
    #1;
    chk("areset_data0", ReadDataD[63:0], 64'h0);
    chk("areset_data1", ReadDataD[127:64], 64'h0);
    chk("areset_haz", 64'(HazardD), 64'd0);
    chk("areset_we", 64'(RegWriteW), 64'd0);
    chk("areset_rdw", 64'(RdW), 64'd0);
    #2 reset = 1'b0;
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 5'd5); #1;
    chk("post_reset_x7", ReadDataD[63:0], 64'h0);
    chk("post_reset_x5", ReadDataD[127:64], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ieu_bypass_pipe.md
Name: ieu_bypass_pipe

Overview:
- Parametrised integer result pipeline with a generalised operand-forwarding network and an integrated register file.
- Replaces the fixed E/M/W result registers and the 3-way forward muxes in the integer datapath.
- Supports any number of result stages and read ports, and late-arriving results (load data).
- Produces per-port hazard flags when a needed result is not yet available.

Parameters:
XLEN, 64, data width
NSTAGES, 3, result stages S0..S(NSTAGES-1); S0 loaded from Execute, S(NSTAGES-1) writes the register file
NREAD, 2, operand read ports
NREGS, 32, architectural registers (16 for RV32E/RV64E)
LATE_STAGE, 2, stage at which late results are merged; legal range 1..NSTAGES-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
StallS  in  NSTAGES  per-stage stall; bit k holds Sk
FlushS  in  NSTAGES  per-stage flush; bit k invalidates Sk
ValidE  in  1  Execute result valid and writes a register
RdE  in  5  Execute destination register
ResultE  in  XLEN  Execute result
ReadyE  in  1  ResultE is final (0 = load/late op)
LateResult  in  XLEN  late data, captured on entry to S[LATE_STAGE]
RsD  in  NREAD*5  source register indices, port i at [5i+4:5i]
ReadDataD  out  NREAD*XLEN  forwarded operand per port
HazardD  out  NREAD  port i needs a not-yet-ready result
RdW  out  5  register written this cycle (debug/trace)
RegWriteW  out  1  register file write this cycle

Behaviour:
- Reset (async) clears: all stage valid, ready, rd and data fields; all registers = 0. Outputs after reset: ReadDataD = 0, HazardD = 0, RegWriteW = 0, RdW = 0.
- Stage entry: {valid, rd, ready, data}.
- S0 loads {ValidE & (RdE != 0) & (RdE < NREGS), RdE, ReadyE, ResultE}.
- Sk (k > 0) loads S(k-1).
- Advance/stall precedence per stage, highest first:
  - FlushS[k]: valid <= 0; wins over stall.
  - StallS[k]: hold.
  - StallS[k-1] and not StallS[k]: load a bubble (valid = 0).
  - Otherwise: advance.
  - For S0 the "previous stage" is the Execute input; ValidE governs it.
- Late merge:
  - When S[LATE_STAGE-1] advances into S[LATE_STAGE] with ready = 0, the loaded data is LateResult and ready is set to 1.
  - Entries at stage >= LATE_STAGE are always ready.
  - An entry with ready = 0 and valid = 1 at S[LATE_STAGE] is illegal; flag it with a simulation assertion.
- Write-back:
  - RegWriteW = S(NSTAGES-1).valid & ~StallS[NSTAGES-1]; RdW = its rd.
  - The register file writes on the rising edge when RegWriteW = 1.
  - x0 is never written.
- Read/forwarding, combinational per port i:
  - Search S0 (youngest) to S(NSTAGES-1) (oldest) for the first entry with valid and rd == RsD[i].
  - If found and ready: ReadDataD[i] = data, HazardD[i] = 0.
  - If found and not ready: ReadDataD[i] = 0, HazardD[i] = 1.
  - If not found: ReadDataD[i] = register file value.
  - RsD = 0 or RsD >= NREGS always yields 0, no hazard.
- Youngest match wins; an older ready entry must never mask a younger not-ready one.
- Same-cycle write + read of the same register: the value comes from S(NSTAGES-1) via forwarding, equal to the value being written.
- Flushed entries are never forwarded or written.
- Reset mid-operation: all in-flight results are discarded; the register file returns to 0.
- Latency: ResultE is visible through forwarding 1 cycle after capture. It reaches the register file NSTAGES cycles after capture with no stalls.

Decomposition:
- cvw package: the stage-entry struct typedef (valid, rd, ready, data), parametrised by XLEN via the cvw_t config.
- Sub-module bypass_sel: one per read port; priority match across stages producing data/hazard. Instantiated NREAD times via generate.
- The register file stays inside as an NREAD-port array with async reset.

Test Plan:
- Back-to-back dependency: ADD x5 = 0x1234 with ValidE=1, ReadyE=1; next cycle RsD[0] = 5 -> ReadDataD[0] = 0x1234, HazardD[0] = 0. After 3 unstalled cycles the register file holds x5 = 0x1234.
- Load-use: ValidE=1, RdE=7, ReadyE=0; next cycle RsD[1] = 7 -> HazardD[1] = 1. Drive LateResult = 0xCAFE on entry to S2, then RsD[1] = 7 -> 0xCAFE, hazard 0.
- Youngest wins: x3 = 0x11 then x3 = 0x22 in consecutive cycles -> RsD = 3 returns 0x22 while both entries are in flight.
- Flush and stall: StallS[0] = 1 for 2 cycles -> S1 receives bubbles and RegWriteW drops. FlushS[1] with an x9 entry in S1 -> x9 is not forwarded and not written; the register file keeps its old value.
- x0 and E-config: ValidE=1, RdE=0, ResultE = 0xFF -> RsD = 0 returns 0, RegWriteW never asserted. With NREGS=16, RdE=20 is discarded and RsD = 20 returns 0.
- Async reset while entries are valid -> all outputs 0 immediately and all registers read 0 in the next cycle.
